// File: rtl/lte_crc_pkg.sv
// Shared LTE CRC definitions: selector codes, generator polynomials,
// CRC byte counts and check FSM states, used by attach and check sides.
package lte_crc_pkg;

  localparam int LEN_W = 14;
  localparam int DW    = 8;

  localparam logic [1:0] CRC_SEL_24A = 2'd0;
  localparam logic [1:0] CRC_SEL_24B = 2'd1;
  localparam logic [1:0] CRC_SEL_16  = 2'd2;
  localparam logic [1:0] CRC_SEL_8   = 2'd3;

  localparam logic [23:0] POLY_24A = 24'h864CFB;
  localparam logic [23:0] POLY_24B = 24'h800063;
  localparam logic [23:0] POLY_16  = 24'h001021;
  localparam logic [23:0] POLY_8   = 24'h00009B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PAY  = 2'd1,
    S_CRC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [1:0] crc_bytes(
    input logic [1:0] sel
  );
    case (sel)
      CRC_SEL_24A: crc_bytes = 2'd3;
      CRC_SEL_24B: crc_bytes = 2'd3;
      CRC_SEL_16:  crc_bytes = 2'd2;
      default:     crc_bytes = 2'd1;
    endcase
  endfunction

  function automatic logic [23:0] poly_of(
    input logic [1:0] sel
  );
    case (sel)
      CRC_SEL_24A: poly_of = POLY_24A;
      CRC_SEL_24B: poly_of = POLY_24B;
      CRC_SEL_16:  poly_of = POLY_16;
      default:     poly_of = POLY_8;
    endcase
  endfunction

  function automatic logic [23:0] msb_of(
    input logic [1:0] sel
  );
    case (sel)
      CRC_SEL_24A: msb_of = 24'h800000;
      CRC_SEL_24B: msb_of = 24'h800000;
      CRC_SEL_16:  msb_of = 24'h008000;
      default:     msb_of = 24'h000080;
    endcase
  endfunction

  function automatic logic [23:0] mask_of(
    input logic [1:0] sel
  );
    case (sel)
      CRC_SEL_24A: mask_of = 24'hFFFFFF;
      CRC_SEL_24B: mask_of = 24'hFFFFFF;
      CRC_SEL_16:  mask_of = 24'h00FFFF;
      default:     mask_of = 24'h0000FF;
    endcase
  endfunction

endpackage

// File: rtl/lte_crc_check_if.sv
// Control, byte-stream and status bundle of the CRC check block.
// slave is the checker's view, master the source/sink side.
interface lte_crc_check_if;
  import lte_crc_pkg::*;

  logic             start;
  logic [1:0]       crc_sel;
  logic [LEN_W-1:0] blk_len;
  logic             i_vld;
  logic [DW-1:0]    i_data;
  logic             i_rdy;
  logic             o_vld;
  logic [DW-1:0]    o_data;
  logic             o_last;
  logic             o_rdy;
  logic             done;
  logic             crc_ok;
  logic             len_err;

  modport master (
    output start, crc_sel, blk_len,
    output i_vld, i_data, o_rdy,
    input  i_rdy, o_vld, o_data,
    input  o_last, done, crc_ok,
    input  len_err
  );

  modport slave (
    input  start, crc_sel, blk_len,
    input  i_vld, i_data, o_rdy,
    output i_rdy, o_vld, o_data,
    output o_last, done, crc_ok,
    output len_err
  );

endinterface

// File: rtl/lte_crc_byte_upd.sv
// One byte of CRC update, MSB first, for any of the four LTE CRCs.
// Narrow CRCs live in the low bits; upper bits are forced to zero.
module lte_crc_byte_upd
  import lte_crc_pkg::*;
(
  input  logic [23:0]   crc_in,
  input  logic [DW-1:0] din,
  input  logic [1:0]    sel,
  output logic [23:0]   crc_out
);

  logic [23:0] c;
  logic [23:0] poly;
  logic [23:0] msb;
  logic [23:0] mask;
  logic        fb;

  // eight unrolled LFSR steps
  always_comb begin
    poly = poly_of(sel);
    msb  = msb_of(sel);
    mask = mask_of(sel);
    c    = crc_in & mask;
    fb   = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = din[i] ^ (|(c & msb));
      c  = (c << 1) & mask;
      if (fb) c = c ^ poly;
    end
    crc_out = c;
  end

endmodule

// File: rtl/lte_crc_check.sv
// Receive-side LTE CRC check: forwards payload bytes, strips
// the CRC bytes and reports whether the block remainder is zero.
module lte_crc_check
  import lte_crc_pkg::*;
(
  input  logic            clk,
  input  logic            ext_asy_rst,
  lte_crc_check_if.slave  bus
);

  logic             rst_s1_q;
  logic             rst_s2_q;
  logic             asy_rst;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [LEN_W-1:0] pay_len_q, pay_len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [23:0]      crc_q, crc_d;
  logic [23:0]      crc_nxt;
  logic             o_vld_q, o_vld_d;
  logic [DW-1:0]    o_data_q, o_data_d;
  logic             o_last_q, o_last_d;
  logic             crc_ok_q, crc_ok_d;
  logic             len_err_q, len_err_d;

  logic [LEN_W-1:0] start_cb;
  logic [LEN_W-1:0] sel_cb;
  logic             len_bad;
  logic             i_rdy;
  logic             in_fire;
  logic             pay_last;
  logic             crc_last;
  logic             crc_zero;

  // async assert, sync release of the internal reset
  always_ff @(posedge clk or posedge ext_asy_rst) begin
    if (ext_asy_rst) begin
      rst_s1_q <= 1'b1;
      rst_s2_q <= 1'b1;
    end else begin
      rst_s1_q <= 1'b0;
      rst_s2_q <= rst_s1_q;
    end
  end

  assign asy_rst  = rst_s2_q;
  assign start_cb = LEN_W'(crc_bytes(bus.crc_sel));
  assign sel_cb   = LEN_W'(crc_bytes(sel_q));
  assign len_bad  = bus.blk_len <= start_cb;
  assign in_fire  = bus.i_vld & i_rdy;
  assign pay_last = cnt_q == pay_len_q - LEN_W'(1);
  assign crc_last = cnt_q == sel_cb - LEN_W'(1);
  assign crc_zero = crc_q == 24'd0;

  lte_crc_byte_upd u_upd (
    .crc_in  (crc_q),
    .din     (bus.i_data),
    .sel     (sel_q),
    .crc_out (crc_nxt)
  );

  // state and datapath registers
  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 2'd0;
      pay_len_q <= '0;
      cnt_q     <= '0;
      crc_q     <= 24'd0;
      o_vld_q   <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      crc_ok_q  <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pay_len_q <= pay_len_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      o_vld_q   <= o_vld_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      crc_ok_q  <= crc_ok_d;
      len_err_q <= len_err_d;
    end
  end

  // block sequencing: header, payload, CRC bytes, verdict
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start && !len_bad) state_d = S_PAY;
      S_PAY:  if (in_fire && pay_last) state_d = S_CRC;
      S_CRC:  if (in_fire && crc_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // counters, CRC register and output holding register
  always_comb begin
    sel_d     = sel_q;
    pay_len_d = pay_len_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    o_vld_d   = o_vld_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    crc_ok_d  = crc_ok_q;
    len_err_d = 1'b0;
    if (state_q == S_IDLE && bus.start) begin
      if (len_bad) begin
        len_err_d = 1'b1;
      end else begin
        sel_d     = bus.crc_sel;
        pay_len_d = bus.blk_len - start_cb;
        cnt_d     = '0;
        crc_d     = 24'd0;
      end
    end
    if (in_fire) begin
      crc_d = crc_nxt;
      if (state_q == S_PAY) begin
        cnt_d = pay_last ? '0 : cnt_q + LEN_W'(1);
      end else begin
        cnt_d = crc_last ? '0 : cnt_q + LEN_W'(1);
      end
    end
    if (in_fire && state_q == S_PAY) begin
      o_vld_d  = 1'b1;
      o_data_d = bus.i_data;
      o_last_d = pay_last;
    end else if (bus.o_rdy) begin
      o_vld_d  = 1'b0;
      o_last_d = 1'b0;
    end
    if (state_q == S_DONE) crc_ok_d = crc_zero;
  end

  // handshake and status outputs
  always_comb begin
    i_rdy = 1'b0;
    unique case (state_q)
      S_PAY:   i_rdy = !o_vld_q || bus.o_rdy;
      S_CRC:   i_rdy = 1'b1;
      default: i_rdy = 1'b0;
    endcase
    bus.i_rdy   = i_rdy;
    bus.o_vld   = o_vld_q;
    bus.o_data  = o_data_q;
    bus.o_last  = o_last_q;
    bus.done    = state_q == S_DONE;
    bus.crc_ok  = (state_q == S_DONE) ? crc_zero : crc_ok_q;
    bus.len_err = len_err_q;
  end

endmodule

// File: tb/tb_lte_crc_check.sv
// Bench for lte_crc_check: table of blocks, scoreboard on the
// payload stream, plus length-error, reset and start corner cases.
module tb_lte_crc_check;
  import lte_crc_pkg::*;

  typedef struct {
    logic [1:0] sel;
    int         pay;
    int         pat;
    int         flip;
    bit         stall;
    bit         vws;
    bit         scrc;
    bit         exp_ok;
  } vec_t;

  logic clk = 1'b0;
  logic ext_asy_rst = 1'b1;
  always #5 clk = ~clk;

  lte_crc_check_if bus();

  lte_crc_check dut (
    .clk         (clk),
    .ext_asy_rst (ext_asy_rst),
    .bus         (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [8:0] sbq[$];
  bit stall_en = 1'b0;
  bit done_allowed = 1'b0;
  bit in_reset = 1'b1;

  function automatic int nbytes(input logic [1:0] sel);
    if (sel == 2'd0 || sel == 2'd1) return 3;
    if (sel == 2'd2) return 2;
    return 1;
  endfunction

  function automatic logic [23:0] ref_crc(
    input logic [7:0] m[$], input logic [1:0] sel
  );
    int w;
    logic [24:0] g;
    logic [24:0] r;
    case (sel)
      2'd0: begin w = 24; g = 25'h1864CFB; end
      2'd1: begin w = 24; g = 25'h1800063; end
      2'd2: begin w = 16; g = 25'h0011021; end
      default: begin w = 8; g = 25'h000019B; end
    endcase
    r = '0;
    foreach (m[k]) begin
      for (int b = 7; b >= 0; b--) begin
        r = (r << 1) | 25'(m[k][b]);
        if (r[w]) r = r ^ g;
      end
    end
    for (int z = 0; z < w; z++) begin
      r = r << 1;
      if (r[w]) r = r ^ g;
    end
    return r[23:0];
  endfunction

  initial begin
    bus.o_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.o_rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic held_v;
    logic [8:0] held;
    logic [8:0] e;
    held_v = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          tests++;
          if (!bus.o_vld || {bus.o_last, bus.o_data} != held) begin
            fails++;
            $display("FAIL hold: got vld=%0b %h want %h",
                     bus.o_vld, {bus.o_last, bus.o_data}, held);
          end
        end
        held_v = bus.o_vld && !bus.o_rdy;
        held = {bus.o_last, bus.o_data};
        if (bus.o_vld && bus.o_rdy) begin
          tests++;
          if (sbq.size() == 0) begin
            fails++;
            $display("FAIL extra_byte: got %h want none",
                     {bus.o_last, bus.o_data});
          end else begin
            e = sbq.pop_front();
            if ({bus.o_last, bus.o_data} != e) begin
              fails++;
              $display("FAIL payload: got %h want %h",
                       {bus.o_last, bus.o_data}, e);
            end
          end
        end
        if (bus.done) begin
          tests++;
          if (!done_allowed || bus.len_err) begin
            fails++;
            $display("FAIL stray_done: got done=1 len_err=%0b want no done",
                     bus.len_err);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input bit is_pay,
                            input bit last);
    bit ok;
    if (stall_en && $urandom_range(0, 3) == 0) begin
      bus.i_vld = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.i_vld = 1'b1;
    bus.i_data = d;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.i_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL i_rdy_timeout: got i_rdy=0 want 1");
    end else if (is_pay) begin
      sbq.push_back({last, d});
    end
    @(posedge clk);
    #1;
    bus.i_vld = 1'b0;
  endtask

  task automatic run_block(input vec_t v, input int abort_after);
    logic [7:0] pay[$];
    logic [7:0] blk[$];
    logic [23:0] c;
    int nb;
    bit got;
    pay.delete();
    blk.delete();
    for (int k = 0; k < v.pay; k++) begin
      case (v.pat)
        0: pay.push_back(8'h31 + 8'(k));
        1: pay.push_back(8'h00);
        default: pay.push_back(8'($urandom_range(0, 255)));
      endcase
    end
    nb = nbytes(v.sel);
    if (v.pat == 0 && v.sel == 2'd2) c = 24'h0031C3;
    else c = ref_crc(pay, v.sel);
    blk = pay;
    for (int k = nb - 1; k >= 0; k--) blk.push_back(c[k*8 +: 8]);
    if (v.flip >= 0) blk[v.flip][0] = ~blk[v.flip][0];
    stall_en = v.stall;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.crc_sel = v.sel;
    bus.blk_len = LEN_W'(blk.size());
    if (v.vws) begin
      bus.i_vld = 1'b1;
      bus.i_data = blk[0];
    end
    @(negedge clk);
    if (v.vws) chk("rdy_in_start", 32'(bus.i_rdy), 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < blk.size(); i++) begin
      if (abort_after >= 0 && i == abort_after) return;
      if (v.scrc && i == v.pay) begin
        bus.start = 1'b1;
        bus.crc_sel = 2'd3;
        bus.blk_len = LEN_W'(5);
      end
      drive_byte(blk[i], i < v.pay, i == v.pay - 1);
      bus.start = 1'b0;
    end
    done_allowed = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 1);
    if (got) chk("crc_ok", 32'(bus.crc_ok), 32'(v.exp_ok));
    @(negedge clk);
    done_allowed = 1'b0;
    chk("idle_rdy_ok", {30'd0, bus.i_rdy, bus.crc_ok},
        {30'd0, 1'b0, v.exp_ok});
    for (int t = 0; t < 400 && sbq.size() != 0; t++) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("o_vld_drained", 32'(bus.o_vld), 0);
    stall_en = 1'b0;
  endtask

  task automatic chk_len_err(input logic [1:0] sel, input int len);
    int pulses;
    bit rdy_seen;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.crc_sel = sel;
    bus.blk_len = LEN_W'(len);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    rdy_seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (bus.len_err) pulses++;
      if (bus.i_rdy) rdy_seen = 1'b1;
    end
    chk("len_err_pulses", 32'(pulses), 1);
    chk("len_err_rdy", 32'(rdy_seen), 0);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t rv;
    bus.start = 1'b0;
    bus.crc_sel = 2'd0;
    bus.blk_len = '0;
    bus.i_vld = 1'b0;
    bus.i_data = '0;

    tbl[0] = '{2'd2, 9, 0, -1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{2'd2, 9, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{2'd0, 40, 1, -1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{2'd1, 100, 2, -1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{2'd3, 1, 2, -1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{2'd0, 30, 2, 10, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{2'd3, 20, 2, 20, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{2'd2, 12, 2, -1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{2'd1, 60, 2, -1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{2'd0, 16380, 2, -1, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        {19'd0, bus.i_rdy, bus.o_vld, bus.o_data, bus.o_last,
         bus.done, bus.crc_ok, bus.len_err}, 0);
    ext_asy_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_reset = 1'b0;
    @(negedge clk);
    chk("post_reset_outs",
        {19'd0, bus.i_rdy, bus.o_vld, bus.o_data, bus.o_last,
         bus.done, bus.crc_ok, bus.len_err}, 0);

    for (int n = 0; n < 3; n++) run_block(tbl[n], -1);
    chk_len_err(2'd3, 1);
    chk_len_err(2'd2, 2);
    chk_len_err(2'd0, 0);
    chk("crc_ok_held", 32'(bus.crc_ok), 1);
    for (int n = 3; n < 10; n++) run_block(tbl[n], -1);

    rv = '{2'd0, 47, 2, -1, 1'b0, 1'b0, 1'b0, 1'b1};
    run_block(rv, 20);
    in_reset = 1'b1;
    bus.i_vld = 1'b0;
    #2;
    ext_asy_rst = 1'b1;
    #1;
    chk("rst_mid_outs",
        {19'd0, bus.i_rdy, bus.o_vld, bus.o_data, bus.o_last,
         bus.done, bus.crc_ok, bus.len_err}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_outs",
        {19'd0, bus.i_rdy, bus.o_vld, bus.o_data, bus.o_last,
         bus.done, bus.crc_ok, bus.len_err}, 0);
    ext_asy_rst = 1'b0;
    sbq.delete();
    repeat (3) @(posedge clk);
    #1;
    in_reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_after_outs",
        {30'd0, bus.done, bus.i_rdy}, 0);
    rv = '{2'd3, 9, 2, -1, 1'b0, 1'b0, 1'b0, 1'b1};
    run_block(rv, -1);
    rv = '{2'd3, 9, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    run_block(rv, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
